// File: rtl/clk_div_ratio_gen_if.sv
// Divide-ratio interface: the ratio producer drives enable/ratio (master),
// the clock divider consumes them and returns the divided clock (slave).
interface clk_div_ratio_gen_if #(
    parameter int RATIO_WD = 8
);
    logic                i_Clk_En;
    logic [RATIO_WD-1:0] i_Div_Ratio;
    logic                o_Div_Clk;
    logic [RATIO_WD-1:0] o_Ratio_Applied;

    modport master (
        output i_Clk_En,
        output i_Div_Ratio,
        input  o_Div_Clk,
        input  o_Ratio_Applied
    );

    modport slave (
        input  i_Clk_En,
        input  i_Div_Ratio,
        output o_Div_Clk,
        output o_Ratio_Applied
    );
endinterface

// File: rtl/clk_div_ratio_gen.sv
// Glitch-free integer clock divider for the UART baud clock; ratio 0/1 or enable low bypasses.
// Optional macro CLK_DIV_DUTY50_EN adds a negedge flop giving exact 50% duty for odd ratios.
module clk_div_ratio_gen #(
    parameter int RATIO_WD = 8
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    clk_div_ratio_gen_if.slave bus
);

    logic [RATIO_WD-1:0] cnt;
    logic [RATIO_WD-1:0] ratio_l;
    logic                en_l;
    logic                div_q;

    logic [RATIO_WD-1:0] cnt_nxt;
    logic                bypass;
    logic                boundary;
    logic                div_out;

    assign cnt_nxt  = cnt + RATIO_WD'(1);
    assign bypass   = !en_l || (ratio_l < RATIO_WD'(2));
    assign boundary = bypass || (cnt == ratio_l - RATIO_WD'(1));

    // Ratio and enable are only sampled at a period boundary, so the
    // divided clock always finishes the period it has started.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt     <= '0;
            ratio_l <= '0;
            en_l    <= 1'b0;
            div_q   <= 1'b0;
        end else if (boundary) begin
            cnt     <= '0;
            ratio_l <= bus.i_Div_Ratio;
            en_l    <= bus.i_Clk_En;
            div_q   <= bus.i_Clk_En && (bus.i_Div_Ratio >= RATIO_WD'(2));
        end else begin
            cnt     <= cnt_nxt;
            div_q   <= (cnt_nxt < (ratio_l >> 1));
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    // Half-cycle extension of the high phase for odd ratios.
    logic div_n;

    always_ff @(negedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            div_n <= 1'b0;
        end else if (bypass) begin
            div_n <= 1'b0;
        end else begin
            div_n <= div_q;
        end
    end

    assign div_out = ratio_l[0] ? (div_q | div_n) : div_q;
`else
    assign div_out = div_q;
`endif

    // Only combinational path to the output: bypass mux onto the reference clock.
    assign bus.o_Div_Clk       = bypass ? i_CLK : div_out;
    assign bus.o_Ratio_Applied = ratio_l;

endmodule
